pwm_duty_sequencer: RTL and testbench

//   Generates the 8-bit duty word `duty` that feeds the LED PWM compare/7-seg display block.
//   Two modes, toggled by a button:
//   - MANUAL: up/down buttons step the duty.
//   - AUTO: FSM "breathing" sequence ramp-up, hold-high, ramp-down, hold-low, repeating.

---
 rtl/pwm_duty_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// Duty-word sequencer for the LED PWM block: manual up/down stepping or an automatic breathing ramp.
// Optional GAMMA_CORR_EN macro adds a registered (lin*lin + lin) >> 8 stage on the duty output.
module pwm_duty_sequencer #(
    parameter int TICK_DIV   = 100000,
    parameter int STEP       = 1,
    parameter int DUTY_MAX   = 255,
    parameter int HOLD_TICKS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [7:0] duty,
    output logic       mode_auto,
    output logic [2:0] state,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        S_MANUAL  = 3'd0,
        S_RAMP_UP = 3'd1,
        S_HOLD_HI = 3'd2,
        S_RAMP_DN = 3'd3,
        S_HOLD_LO = 3'd4
    } state_e;

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] MAX9  = 9'(DUTY_MAX);

    state_e            state_q, state_d;
    logic              mode_auto_q, mode_auto_d;
    logic [7:0]        lin_q, lin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cycle_done_q, cycle_done_d;
    logic [2:0]        up_sync_q, dn_sync_q, md_sync_q;
    logic              up_press, dn_press, md_press, tick;

    // 9-bit intermediate so the step can never wrap past either limit
    function automatic logic [7:0] sat_add(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + STEP9;
        if (s > MAX9) s = MAX9;
        return s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] v);
        logic [8:0] s;
        if ({1'b0, v} < STEP9) s = '0;
        else                   s = {1'b0, v} - STEP9;
        return s[7:0];
    endfunction

    // [0]=s1, [1]=s2, [2]=s3 edge register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_sync_q <= '0;
            dn_sync_q <= '0;
            md_sync_q <= '0;
        end else begin
            up_sync_q <= {up_sync_q[1:0], btn_up};
            dn_sync_q <= {dn_sync_q[1:0], btn_down};
            md_sync_q <= {md_sync_q[1:0], btn_mode};
        end
    end

    assign up_press = up_sync_q[1] & ~up_sync_q[2];
    assign dn_press = dn_sync_q[1] & ~dn_sync_q[2];
    assign md_press = md_sync_q[1] & ~md_sync_q[2];
    assign tick     = mode_auto_q && (cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        mode_auto_d  = mode_auto_q;
        lin_d        = lin_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        cycle_done_d = 1'b0;
        if (mode_auto_q) cnt_d = tick ? '0 : cnt_q + 1'b1;

        if (md_press) begin
            cnt_d  = '0;
            hold_d = '0;
            if (state_q == S_MANUAL) begin
                state_d     = S_RAMP_UP;
                mode_auto_d = 1'b1;
            end else begin
                state_d     = S_MANUAL;
                mode_auto_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_MANUAL: begin
                    if (up_press && !dn_press)      lin_d = sat_add(lin_q);
                    else if (dn_press && !up_press) lin_d = sat_sub(lin_q);
                end
                S_RAMP_UP: if (tick) begin
                    lin_d = sat_add(lin_q);
                    if ({1'b0, lin_d} == MAX9) state_d = S_HOLD_HI;
                end
                S_HOLD_HI: if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = S_RAMP_DN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_RAMP_DN: if (tick) begin
                    lin_d = sat_sub(lin_q);
                    if (lin_d == 8'd0) state_d = S_HOLD_LO;
                end
                S_HOLD_LO: if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d       = '0;
                        state_d      = S_RAMP_UP;
                        cycle_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = S_MANUAL;
                    mode_auto_d = 1'b0;
                    cnt_d       = '0;
                    hold_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_MANUAL;
            mode_auto_q  <= 1'b0;
            lin_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_auto_q  <= mode_auto_d;
            lin_q        <= lin_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            cycle_done_q <= cycle_done_d;
        end
    end

`ifdef GAMMA_CORR_EN
    logic [7:0] duty_q;

    // (lin^2 + lin) >> 8 keeps both endpoints exact: 0 -> 0, 255 -> 255
    function automatic logic [7:0] gamma(input logic [7:0] v);
        logic [15:0] p;
        p = 16'(v) * 16'(v) + 16'(v);
        return p[15:8];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) duty_q <= '0;
        else      duty_q <= gamma(lin_q);
    end

    assign duty = duty_q;
`else
    assign duty = lin_q;
`endif

    assign state      = state_q;
    assign mode_auto  = mode_auto_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: manual stepping table plus hand-written AUTO/reset sequences.
module tb_pwm_duty_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_mode;
    logic [7:0] duty;
    logic       mode_auto;
    logic [2:0] state;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       up;
        logic       down;
        logic [7:0] exp_duty;
    } vec_t;

    vec_t vecs[35];

    pwm_duty_sequencer #(
        .TICK_DIV  (4),
        .STEP      (16),
        .DUTY_MAX  (255),
        .HOLD_TICKS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_mode  (btn_mode),
        .duty      (duty),
        .mode_auto (mode_auto),
        .state     (state),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int g(input int lin);
`ifdef GAMMA_CORR_EN
        return (lin * lin + lin) >> 8;
`else
        return lin;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic m);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_mode = m;
        repeat (5) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic gamma_wait();
`ifdef GAMMA_CORR_EN
        @(posedge clk);
`endif
    endtask

    initial begin
        bit found;
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;

        for (int i = 0; i < 17; i++) begin
            vecs[i].up = 1'b1; vecs[i].down = 1'b0;
            vecs[i].exp_duty = (i < 15) ? 8'(16 * (i + 1)) : 8'd255;
            vecs[17 + i].up = 1'b0; vecs[17 + i].down = 1'b1;
            vecs[17 + i].exp_duty = (i < 15) ? 8'(255 - 16 * (i + 1)) : 8'd0;
        end
        vecs[34].up = 1'b1; vecs[34].down = 1'b1; vecs[34].exp_duty = 8'd0;

        repeat (3) @(negedge clk);
        check("reset_duty", duty, 0);
        check("reset_state", state, 0);
        check("reset_mode", mode_auto, 0);
        check("reset_cdone", cycle_done, 0);
        rst = 1'b1;

        // Manual stepping: saturating up, saturating down, simultaneous up+down ignored
        for (int i = 0; i < 35; i++) begin
            press(vecs[i].up, vecs[i].down, 1'b0);
            check($sformatf("manual_duty[%0d]", i), duty, g(vecs[i].exp_duty));
            check($sformatf("manual_state[%0d]", i), state, 0);
        end

        // Held button yields exactly one step
        @(negedge clk); btn_up = 1'b1;
        repeat (100) @(negedge clk);
        btn_up = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_one_press", duty, g(16));

        // Three-clock press latency
        @(negedge clk); btn_up = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("latency_edge2", duty, g(16));
        @(posedge clk); gamma_wait(); #1;
        check("latency_edge3", duty, g(32));
        btn_up = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("back_to_zero", duty, g(0));

        // Full breathing cycle from duty 0
        @(negedge clk); btn_mode = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("auto_entry_state", state, 1);
        check("auto_entry_mode", mode_auto, 1);
        btn_mode = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            repeat (4) @(posedge clk); #1;
            check($sformatf("ramp_up_duty[%0d]", k), duty, g((k < 16) ? 16 * k : 255));
            check($sformatf("ramp_up_state[%0d]", k), state, (k < 16) ? 1 : 2);
        end
        repeat (6) @(posedge clk); #1;
        check("hold_hi_still", state, 2);
        @(posedge clk); #1;
        check("hold_hi_exit", state, 3);
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            repeat (4) @(posedge clk); #1;
            check($sformatf("ramp_dn_duty[%0d]", k), duty, g((k < 16) ? 255 - 16 * k : 0));
            check($sformatf("ramp_dn_state[%0d]", k), state, (k < 16) ? 3 : 4);
        end
        repeat (6) @(posedge clk); #1;
        check("hold_lo_still", state, 4);
        check("cdone_early", cycle_done, 0);
        @(posedge clk); #1;
        check("cycle_restart_state", state, 1);
        check("cdone_pulse", cycle_done, 1);
        @(posedge clk); #1;
        check("cdone_single", cycle_done, 0);

        // Mode press during RAMP_DN at 127 freezes duty
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (state == 3'd3 && duty == 8'(g(127))) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_ramp_dn_127: got timeout expected state 3 duty 127");
        end
        btn_mode = 1'b1;
        repeat (3) @(posedge clk); gamma_wait(); #1;
        check("freeze_state", state, 0);
        check("freeze_mode", mode_auto, 0);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        check("freeze_duty", duty, g(127));
        press(1'b1, 1'b0, 1'b0);
        check("after_freeze_up", duty, g(143));

        // Asynchronous reset mid RAMP_UP at duty 96
        press(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (state == 3'd1 && duty == 8'(g(96))) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_ramp_up_96: got timeout expected state 1 duty 96");
        end
        #1 rst = 1'b0;
        #1;
        check("async_rst_duty", duty, 0);
        check("async_rst_state", state, 0);
        check("async_rst_mode", mode_auto, 0);
        check("async_rst_cdone", cycle_done, 0);
        @(negedge clk); rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
